// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind an SPI slave: address/data words in, read bytes out.
// The armed flags live in a four-state FSM; burst mode post-increments the pointers.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int ADDR_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam int                   IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   LP_DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LP_WRAP  = (ADDR_SIZE)'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] LP_ONE   = (ADDR_SIZE)'(1);
  localparam logic                 LP_BURST = (ADDR_INC != 0);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WR_ARMED   = 2'b01,
    RD_ARMED   = 2'b10,
    BOTH_ARMED = 2'b11
  } state_t;

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic [1:0]           w_op;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [7:0]           w_data;
  logic                 w_addr_ok;
  logic                 w_wr_armed;
  logic                 w_rd_armed;
  logic                 w_do_wr;
  logic                 w_do_rd;
  logic                 w_wr_next;
  logic                 w_rd_next;
  logic                 w_err;
  logic [ADDR_SIZE-1:0] w_wr_ptr_next;
  logic [ADDR_SIZE-1:0] w_rd_ptr_next;

  assign w_op       = din[9:8];
  assign w_addr     = din[ADDR_SIZE-1:0];
  assign w_data     = din[7:0];
  assign w_addr_ok  = ({1'b0, w_addr} < LP_DEPTH);
  assign w_wr_armed = (r_state == WR_ARMED) || (r_state == BOTH_ARMED);
  assign w_rd_armed = (r_state == RD_ARMED) || (r_state == BOTH_ARMED);
  assign w_do_wr    = rx_valid && (w_op == OP_WR_DATA) && w_wr_armed;
  assign w_do_rd    = rx_valid && (w_op == OP_RD_DATA) && w_rd_armed;

  // Decode the current word into next armed flags, pointers and error.
  always_comb begin
    w_wr_next     = w_wr_armed;
    w_rd_next     = w_rd_armed;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_err         = 1'b0;
    if (rx_valid) begin
      case (w_op)
        OP_WR_ADDR: begin
          if (w_addr_ok) begin
            w_wr_next     = 1'b1;
            w_wr_ptr_next = w_addr;
          end else begin
            w_err = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (w_wr_armed) begin
            w_wr_next = LP_BURST;
            if (LP_BURST) w_wr_ptr_next = (r_wr_ptr + LP_ONE) & LP_WRAP;
            else          w_wr_ptr_next = r_wr_ptr;
          end else begin
            w_err = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (w_addr_ok) begin
            w_rd_next     = 1'b1;
            w_rd_ptr_next = w_addr;
          end else begin
            w_err = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (w_rd_armed) begin
            w_rd_next = LP_BURST;
            if (LP_BURST) w_rd_ptr_next = (r_rd_ptr + LP_ONE) & LP_WRAP;
            else          w_rd_ptr_next = r_rd_ptr;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end else begin
      w_err = 1'b0;
    end
  end

  // FSM, pointers and registered outputs; tx_valid holds until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
    end else if (rx_valid) begin
      r_state  <= state_t'({w_rd_next, w_wr_next});
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      tx_valid <= w_do_rd;
      cmd_err  <= w_err;
      if (w_do_rd) dout <= r_mem[r_rd_ptr[IDX_W-1:0]];
    end else begin
      cmd_err <= 1'b0;
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_data;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port synchronous RAM with a command decoder. Sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid word stream and executes write-address, write-data, read-address and read-data commands.
- Returns read bytes on dout/tx_valid, which feed the slave's tx_data/tx_valid inputs for shifting out on MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must be a power of two, at most 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width in bits; address is din[ADDR_SIZE-1:0].
- ADDR_INC, 0, when 1 the write and read pointers post-increment after each data command (burst mode).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  command word from SPI slave; din[9:8] = opcode, din[7:0] = address or data.
- rx_valid  input  1  din is valid this cycle; one-cycle pulse per word.
- dout  output  8  read data to SPI slave tx_data.
- tx_valid  output  1  dout holds valid read data.
- cmd_err  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, tx_valid=0, cmd_err=0.
  - wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0.
  - RAM contents are not reset.
  - Reset mid-command aborts the command with no RAM write.
- Commands act only on a rising edge where rx_valid=1. din is ignored when rx_valid=0.
- Opcode 00, WR_ADDR: wr_ptr <= din[ADDR_SIZE-1:0]; wr_armed <= 1. No RAM access.
- Opcode 01, WR_DATA:
  - If wr_armed: mem[wr_ptr] <= din[7:0] on the same edge.
  - If ADDR_INC=1, also wr_ptr <= wr_ptr+1, wrapping modulo MEM_DEPTH.
  - If not wr_armed: no write, cmd_err pulses 1 cycle.
  - wr_armed is cleared after the write when ADDR_INC=0 and stays set when ADDR_INC=1.
- Opcode 10, RD_ADDR: rd_ptr <= din[ADDR_SIZE-1:0]; rd_armed <= 1.
- Opcode 11, RD_DATA:
  - If rd_armed: dout <= mem[rd_ptr] and tx_valid <= 1, both visible the cycle after the rx_valid edge (latency 1).
  - If ADDR_INC=1, also rd_ptr <= rd_ptr+1, wrapping modulo MEM_DEPTH.
  - rd_armed clears after the read when ADDR_INC=0.
  - If not rd_armed: dout unchanged, tx_valid stays 0, cmd_err pulses.
  - din[7:0] is a don't-care.
- Addresses >= MEM_DEPTH (MEM_DEPTH < 2**ADDR_SIZE): address command is rejected, pointer and armed flag unchanged, cmd_err pulses.
- tx_valid handshake:
  - Once set, tx_valid is held high with dout stable until the next rx_valid edge of any opcode.
  - That edge clears tx_valid, unless the command is a successful RD_DATA, which reloads dout and keeps tx_valid=1.
- Read-during-write: a RD_DATA to the address written by a WR_DATA in the immediately preceding accepted command returns the new data.
- Internal FSM over {IDLE, WR_ARMED, RD_ARMED, BOTH_ARMED} encodes the armed flags. Transitions occur only on rx_valid edges as described above.
- cmd_err is asserted only in the cycle after the offending rx_valid edge.

Test Plan:
- Reset, then write: rx_valid pulses din=0x0_3A (WR_ADDR 0x3A) then 0x1_C5 (WR_DATA) -> mem[0x3A]=0xC5, cmd_err=0, tx_valid=0.
- Read back: din=0x2_3A then 0x3_00 -> one cycle after second pulse dout=0xC5, tx_valid=1. Both stay held for 20 idle cycles. Next din=0x0_10 -> tx_valid=0.
- Out of order: after reset, din=0x1_55 then 0x3_00 -> two cmd_err pulses, tx_valid=0, mem unchanged. A later read of any address shows no 0x55 written.
- Burst, ADDR_INC=1: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). RD_ADDR 0xFF, two RD_DATA -> dout 0x22 then 0x33.
- Reset mid-operation: WR_ADDR 0x40, assert rst_n=0 for 1 cycle, then WR_DATA 0x77 -> cmd_err pulses, mem[0x40] unchanged, all outputs 0 during reset.
- Parameter MEM_DEPTH=128, ADDR_SIZE=8: WR_ADDR 0x90 -> cmd_err pulse, wr_armed stays 0. A following WR_DATA also raises cmd_err.
